pcpi_result_nibble_tx: RTL
==========================

Name: pcpi_result_nibble_tx

Overview:
Transmit side of the 4-bit nibble link. The existing instruction receiver takes a 32-bit word in as nibbles, using a strobe and an acknowledge. This block returns a 32-bit PCPI result (pcpi_rd) to the off-chip host as nibbles, LSB nibble first. It sits between the PCPI coprocessor's result port and the uo_out/uio pins of the top-level wrapper, and uses a four-phase valid/ack handshake per nibble.

Parameters:
NIBBLES, 8, nibbles per word; word width is 4*NIBBLES.
SYNC_STAGES, 2, flops in the nib_ack synchronizer; minimum 2.
TIMEOUT_CYCLES, 1024, max cycles spent waiting in a single handshake phase; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
result_valid  input  1  a result word is offered on result_data
result_data  input  4*NIBBLES  word to send (pcpi_rd)
result_ready  output  1  block can accept a word this cycle
nib_data  output  4  current nibble to the pin
nib_valid  output  1  nibble on nib_data is valid (host "sending_current" equivalent)
nib_last  output  1  high while the final nibble of a word is being presented
nib_ack  input  1  host acknowledge; asynchronous to clk
tx_busy  output  1  a word is in flight
tx_error  output  1  one-cycle pulse when a frame is aborted on timeout

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except result_ready; state IDLE; index 0; timeout counter 0; synchronizer flops 0.
- result_ready = (state==IDLE) and rst_n deasserted; it is combinational from state only.
- nib_ack goes through a SYNC_STAGES flop chain; ack_s is the last stage. Only ack_s is used internally.
- States:
  - IDLE: if result_valid & result_ready at edge T, latch result_data into the shift register, set index=0, and go to PRESENT. At T+1, nib_valid=1 and nib_data=word[3:0].
  - PRESENT: nib_valid=1 and nib_data=shreg[3:0] are registered and held stable. When ack_s==1, go to RELEASE; nib_valid drops at the next edge.
  - RELEASE: nib_valid=0 and nib_data holds its last value. When ack_s==0:
    - if index==NIBBLES-1, go to IDLE;
    - otherwise shift shreg right by 4, increment index, and go to PRESENT.
- Flags:
  - nib_last = nib_valid & (index==NIBBLES-1).
  - tx_busy = (state!=IDLE).
- A word is never dropped or duplicated. A new result_valid while busy is not accepted, and the producer must hold it.
- Back-to-back words: IDLE lasts at least one cycle between frames, so result_ready is high for at least one cycle.
- Timeout:
  - The counter clears on every state change and increments each cycle in PRESENT or RELEASE.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without the awaited ack level, go to IDLE. At the same edge, nib_valid=0, tx_error pulses for 1 cycle, and the frame is discarded.
- ack_s already high on entry to PRESENT (host stuck high): this counts as an ack. The block proceeds to RELEASE and waits for the low level, so no nibble is skipped silently.
- Reset mid-frame: asynchronous clear to IDLE; nib_valid drops immediately and the partial frame is lost.
- Arithmetic: index is $clog2(NIBBLES) bits and compared against NIBBLES-1, with no wrap-around beyond that. The counter width is $clog2(TIMEOUT_CYCLES+1), and it saturates at its maximum value.
- Minimum per-nibble time with an ideal host is 2*(SYNC_STAGES+1) cycles.

Test Plan:
1. Reset, then offer result_data=0xDEADBEEF with a host model that acks 1 cycle after nib_valid and releases 1 cycle after nib_valid falls -> nibbles F,E,E,B,D,A,E,D in order; nib_last high only on D (the 8th); result_ready high again after the final release; tx_error never pulses.
2. Hold result_valid high with 0x12345678, then 0x9ABCDEF0 presented mid-frame -> the second word is not accepted until IDLE; the outputs are 8,7,6,5,4,3,2,1 and then 0,F,E,D,C,B,A,9.
3. Host never acks, TIMEOUT_CYCLES=16, word 0x0000000A -> nib_valid=1 with nib_data=A for 16 cycles, then nib_valid=0 with a single-cycle tx_error, and the block returns to IDLE with result_ready=1.
4. Assert rst_n low asynchronously (between edges) during nibble 3 of 0xCAFEF00D -> nib_valid, tx_busy and nib_last go to 0 without waiting for a clock edge. The next word 0x00000001 starts again at nibble 1.
5. nib_ack tied high before the frame starts -> PRESENT exits after the sync latency into RELEASE, and the block stalls with nib_valid=0. After ack is dropped, the nibble index advances by exactly one.
6. Random ack delays of 0-20 cycles over 200 random words -> a scoreboard reassembles the LSB-first nibbles into exactly the offered words; nib_data never changes while nib_valid=1.

Source files
------------

// File: rtl/pcpi_result_nibble_tx.sv
// Nibble-serial transmitter for PCPI results: sends a word LSB nibble first
// over a four-phase valid/ack handshake with a host clocked independently.
module pcpi_result_nibble_tx #(
  parameter int unsigned NIBBLES        = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 result_valid,
  input  logic [4*NIBBLES-1:0] result_data,
  output logic                 result_ready,
  output logic [3:0]           nib_data,
  output logic                 nib_valid,
  output logic                 nib_last,
  input  logic                 nib_ack,
  output logic                 tx_busy,
  output logic                 tx_error
);

  localparam int unsigned WORD_W   = 4 * NIBBLES;
  localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LAST_IDX = NIBBLES - 1;
  localparam int unsigned TO_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [WORD_W-1:0]    shreg, shreg_d;
  logic [WORD_W-1:0]    shreg_shift;
  logic [IDX_W-1:0]     index, index_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                 ack_s;
  logic                 timeout_hit;
  logic                 last_idx;

  logic [3:0]           nib_data_d;
  logic                 nib_valid_d;
  logic                 nib_last_d;
  logic                 tx_busy_d;
  logic                 tx_error_d;

  // Ready depends only on state; forced low while reset is asserted.
  assign result_ready = (state == IDLE) && rst_n;

  assign ack_s       = ack_sync[SYNC_STAGES-1];
  assign shreg_shift = shreg >> 4;
  assign last_idx    = (index == IDX_W'(LAST_IDX));
  assign timeout_hit = TO_EN && (cnt >= CNT_W'(TO_LAST));

  // Bring the host acknowledge into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], nib_ack};
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      index     <= '0;
      cnt       <= '0;
      nib_data  <= '0;
      nib_valid <= 1'b0;
      nib_last  <= 1'b0;
      tx_busy   <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      index     <= index_d;
      cnt       <= cnt_d;
      nib_data  <= nib_data_d;
      nib_valid <= nib_valid_d;
      nib_last  <= nib_last_d;
      tx_busy   <= tx_busy_d;
      tx_error  <= tx_error_d;
    end
  end

  // Handshake sequencing: present a nibble, wait for ack high, then ack low.
  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    index_d     = index;
    nib_data_d  = nib_data;
    nib_valid_d = nib_valid;
    tx_error_d  = 1'b0;

    unique case (state)
      IDLE: begin
        nib_valid_d = 1'b0;
        if (result_valid) begin
          shreg_d     = result_data;
          index_d     = '0;
          nib_data_d  = result_data[3:0];
          nib_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end

      PRESENT: begin
        // A level already high on entry is treated as the ack for this nibble.
        if (ack_s) begin
          nib_valid_d = 1'b0;
          state_d     = RELEASE;
        end else if (timeout_hit) begin
          nib_valid_d = 1'b0;
          tx_error_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      RELEASE: begin
        if (!ack_s) begin
          if (last_idx) begin
            state_d = IDLE;
          end else begin
            shreg_d     = shreg_shift;
            index_d     = index + IDX_W'(1);
            nib_data_d  = shreg_shift[3:0];
            nib_valid_d = 1'b1;
            state_d     = PRESENT;
          end
        end else if (timeout_hit) begin
          tx_error_d = 1'b1;
          state_d    = IDLE;
        end
      end

      default: begin
        nib_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    tx_busy_d  = (state_d != IDLE);
    nib_last_d = nib_valid_d && (index_d == IDX_W'(LAST_IDX));
  end

  // Phase timer: cleared on any state change, saturating otherwise.
  always_comb begin
    cnt_d = cnt;
    if (state_d != state) begin
      cnt_d = '0;
    end else if ((state != IDLE) && (cnt != {CNT_W{1'b1}})) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

endmodule
